// File: rtl/adau_i2s_tx_pkg.sv
// Shared constants and the slot bit-mapping helper for the ADAU I2S transmitter.
package adau_i2s_tx_pkg;

    localparam int AUDIO_SAMPLE_BITS = 24;
    localparam int I2S_SLOT_BITS     = 32;
    localparam int I2S_FRAME_BITS    = 64;
    localparam int AUDIO_FRAME_BITS  = 2 * AUDIO_SAMPLE_BITS;

    // Bit driven for frame position bit_cnt: sample MSB at slot position 1, zero padding elsewhere.
    function automatic logic slot_bit(input logic [AUDIO_FRAME_BITS-1:0] frame,
                                      input logic [5:0]                  bit_cnt);
        logic [AUDIO_SAMPLE_BITS-1:0] sample;
        logic [4:0]                   pos;
        sample = bit_cnt[5] ? frame[AUDIO_SAMPLE_BITS-1:0]
                            : frame[AUDIO_FRAME_BITS-1:AUDIO_SAMPLE_BITS];
        pos    = bit_cnt[4:0];
        if (pos == 5'd0 || pos > 5'(AUDIO_SAMPLE_BITS)) begin
            return 1'b0;
        end
        return sample[5'(AUDIO_SAMPLE_BITS) - pos];
    endfunction

endpackage

// File: rtl/adau_i2s_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output and registered fill level.
module sync_fifo
    import adau_i2s_tx_pkg::*;
#(
    parameter int WIDTH      = AUDIO_FRAME_BITS,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  do_push, do_pop;

    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array is not reset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/adau_i2s_tx.sv
// ADAU I2S master transmitter: frame FIFO feeding a 64-BCLK-per-frame serializer.
module adau_i2s_tx
    import adau_i2s_tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int BCLK_HALF  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [47:0]         audio_in,
    input  logic                audio_valid,
    output logic                audio_full,
    output logic [DEPTH_LOG2:0] fill_level,
    output logic                underrun,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    localparam int               DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int               BIT_W    = $clog2(I2S_FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_IDLE = BIT_W'(I2S_FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic                        bclk_q, bclk_d;
    logic                        lrclk_q, lrclk_d;
    logic                        sdata_q, sdata_d;
    logic                        underrun_q, underrun_d;
    logic [AUDIO_FRAME_BITS-1:0] frame_q, frame_d;

    logic                        fifo_pop;
    logic                        fifo_empty;
    logic [AUDIO_FRAME_BITS-1:0] fifo_dout;

    sync_fifo #(
        .WIDTH      (AUDIO_FRAME_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (audio_valid),
        .pop   (fifo_pop),
        .din   (audio_in),
        .dout  (fifo_dout),
        .full  (audio_full),
        .empty (fifo_empty),
        .level (fill_level)
    );

    always_comb begin
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;
        fifo_pop   = 1'b0;
        if (!enable) begin
            div_cnt_d = '0;
            bit_cnt_d = BIT_IDLE;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
        end else if (div_cnt_q != DIV_LAST) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
            div_cnt_d = '0;
            bclk_d    = !bclk_q;
            // BCLK falling: advance the bit position and present its data a half period before the rise.
            if (bclk_q) begin
                bit_cnt_d = bit_cnt_q + BIT_ONE;
                if (bit_cnt_d == '0) begin
                    fifo_pop   = !fifo_empty;
                    underrun_d = fifo_empty;
                    frame_d    = fifo_empty ? '0 : fifo_dout;
                end
                lrclk_d = bit_cnt_d[BIT_W-1];
                sdata_d = slot_bit(frame_d, bit_cnt_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= BIT_IDLE;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            frame_q    <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            frame_q    <= frame_d;
        end
    end

    assign underrun  = underrun_q;
    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;

endmodule

// File: tb/tb_adau_i2s_tx.sv
// Self-checking bench: per-cycle behavioural model for the default DUT, frame decoder for a fast DUT.
module tb_adau_i2s_tx;

    localparam int H     = 16;
    localparam int HF    = 2;
    localparam int DEPTH = 16;
    localparam logic [63:0] LR_PATTERN = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] PAD_MASK   = 64'hFE00_0001_FE00_0001;

    logic        clk = 1'b0;
    logic        reset, enable, audio_valid;
    logic [47:0] audio_in;
    logic        audio_full, underrun, i2s_bclk, i2s_lrclk, i2s_sdata;
    logic [4:0]  fill_level;

    logic        f_en, f_valid;
    logic [47:0] f_audio_in;
    logic        f_full, f_underrun, f_bclk, f_lrclk, f_sdata;
    logic [4:0]  f_fill_level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit checking = 0;

    adau_i2s_tx #(.DEPTH_LOG2(4), .BCLK_HALF(H)) dut (
        .clk(clk), .reset(reset), .enable(enable), .audio_in(audio_in),
        .audio_valid(audio_valid), .audio_full(audio_full), .fill_level(fill_level),
        .underrun(underrun), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata)
    );

    adau_i2s_tx #(.DEPTH_LOG2(4), .BCLK_HALF(HF)) dut_fast (
        .clk(clk), .reset(reset), .enable(f_en), .audio_in(f_audio_in),
        .audio_valid(f_valid), .audio_full(f_full), .fill_level(f_fill_level),
        .underrun(f_underrun), .i2s_bclk(f_bclk), .i2s_lrclk(f_lrclk), .i2s_sdata(f_sdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model of the default DUT: a frame queue plus the elapsed enabled-edge count.
    logic [47:0] m_q[$];
    int          m_n = 0;
    logic [47:0] m_frame = '0;
    logic        m_und = 1'b0;

    always @(posedge clk) begin
        bit accept;
        if (reset) begin
            m_q.delete();
            m_n     = 0;
            m_frame = '0;
            m_und   = 1'b0;
        end else begin
            accept = audio_valid && (m_q.size() < DEPTH);
            m_und  = 1'b0;
            if (enable) begin
                m_n++;
                if ((m_n % (2 * H) == 0) && ((m_n / (2 * H)) % 64 == 1)) begin
                    if (m_q.size() == 0) begin
                        m_frame = '0;
                        m_und   = 1'b1;
                    end else begin
                        m_frame = m_q.pop_front();
                    end
                end
            end else begin
                m_n = 0;
            end
            if (accept) m_q.push_back(audio_in);
        end
    end

    int          e_k, e_bc, e_pos;
    logic [23:0] e_smp;
    logic        e_lr, e_sd;

    always @(negedge clk) begin
        if (checking) begin
            e_k = m_n / (2 * H);
            if (e_k == 0) begin
                e_lr = 1'b0;
                e_sd = 1'b0;
            end else begin
                e_bc  = (63 + e_k) % 64;
                e_pos = e_bc % 32;
                e_lr  = (e_bc >= 32);
                e_smp = (e_bc < 32) ? m_frame[47:24] : m_frame[23:0];
                e_sd  = (e_pos >= 1 && e_pos <= 24) ? e_smp[24 - e_pos] : 1'b0;
            end
            check("bclk", i2s_bclk, 64'((m_n / H) % 2));
            check("lrclk", i2s_lrclk, e_lr);
            check("sdata", i2s_sdata, e_sd);
            check("underrun", underrun, m_und);
            check("fill_level", fill_level, m_q.size());
            check("audio_full", audio_full, m_q.size() == DEPTH);
        end
    end

    // Decoder for the fast DUT: rebuild each frame from BCLK-rise samples and score it.
    logic [47:0] f_exp_q[$];
    int          f_r, f_idx, f_frames = 0, f_data_frames = 0, f_last_end = 0, f_last_period = 0;
    logic        f_prev, f_und, f_end_valid;
    logic [63:0] f_bits, f_lr;
    logic [47:0] f_dec, f_exp, f_last_data = '0;

    always @(negedge clk) begin
        if (reset || !f_en) begin
            f_r = 0; f_prev = 1'b0; f_und = 1'b0; f_end_valid = 1'b0;
            if (reset) begin
                f_frames = 0;
                f_data_frames = 0;
            end
        end else begin
            if (f_underrun) f_und = 1'b1;
            if (f_bclk && !f_prev) begin
                f_r++;
                if (f_r >= 2) begin
                    f_idx = (f_r - 2) % 64;
                    f_bits[f_idx] = f_sdata;
                    f_lr[f_idx]   = f_lrclk;
                    if (f_idx == 63) begin
                        for (int i = 0; i < 24; i++) begin
                            f_dec[47 - i] = f_bits[1 + i];
                            f_dec[23 - i] = f_bits[33 + i];
                        end
                        if (f_und) begin
                            f_exp = '0;
                        end else begin
                            check("f_frame_source", f_exp_q.size() > 0, 1);
                            f_exp = (f_exp_q.size() > 0) ? f_exp_q.pop_front() : '0;
                            f_data_frames++;
                            f_last_data = f_dec;
                        end
                        check("f_frame_data", f_dec, f_exp);
                        check("f_lrclk_pattern", f_lr, LR_PATTERN);
                        check("f_pad_zero", f_bits & PAD_MASK, 0);
                        if (f_end_valid) begin
                            f_last_period = cyc - f_last_end;
                            check("f_frame_period", f_last_period, 128 * HF);
                        end
                        f_last_end  = cyc;
                        f_end_valid = 1'b1;
                        f_frames++;
                        f_und = 1'b0;
                    end
                end
            end
            f_prev = f_bclk;
        end
    end

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; audio_valid = 1'b0; audio_in = '0;
        f_en = 1'b0; f_valid = 1'b0; f_audio_in = '0;
        f_exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Hold valid with the frame until the producer handshake accepts it or the budget runs out.
    task automatic push_frame(input int which, input logic [47:0] d, input int budget, output int ok);
        logic full_now;
        int   waited;
        ok = 0; waited = 0;
        if (which == 0) begin audio_in = d; audio_valid = 1'b1; end
        else begin f_audio_in = d; f_valid = 1'b1; end
        while (ok == 0 && waited < budget) begin
            full_now = (which == 0) ? audio_full : f_full;
            @(negedge clk);
            waited++;
            if (!full_now) ok = 1;
        end
        if (which == 0) audio_valid = 1'b0;
        else f_valid = 1'b0;
        if (which == 1 && ok == 1) f_exp_q.push_back(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok, c0, r, und_cnt, ones, b1, b2, l1, l2;
        logic prev_b, prev_l;
        logic [63:0] bits, lr;
        logic [23:0] left, right;
        logic [47:0] d;

        do_reset();
        checking = 1;
        check("rst_bclk", i2s_bclk, 0);
        check("rst_lrclk", i2s_lrclk, 0);
        check("rst_sdata", i2s_sdata, 0);
        check("rst_fill", fill_level, 0);
        check("rst_full", audio_full, 0);
        check("rst_underrun", underrun, 0);

        // Empty FIFO: underrun each frame, silent data, nominal BCLK and LRCLK periods.
        enable = 1'b1;
        und_cnt = 0; ones = 0; b1 = -1; b2 = -1; l1 = -1; l2 = -1; prev_b = 0; prev_l = 0;
        for (int t = 0; t < 6200; t++) begin
            @(negedge clk);
            if (underrun) und_cnt++;
            if (i2s_sdata) ones++;
            if (i2s_bclk && !prev_b) begin if (b1 < 0) b1 = cyc; else if (b2 < 0) b2 = cyc; end
            if (i2s_lrclk && !prev_l) begin if (l1 < 0) l1 = cyc; else if (l2 < 0) l2 = cyc; end
            prev_b = i2s_bclk; prev_l = i2s_lrclk;
        end
        check("t1_underruns", und_cnt, 4);
        check("t1_sdata_ones", ones, 0);
        check("t1_bclk_period", b2 - b1, 2 * H);
        check("t1_lrclk_period", l2 - l1, 128 * H);

        // Single known frame decoded from BCLK rises.
        do_reset();
        push_frame(0, {24'hA5A5A5, 24'h5A5A5A}, 10, ok);
        check("t2_push_ok", ok, 1);
        enable = 1'b1; r = 0; prev_b = 0; bits = '0; lr = '0;
        for (int t = 0; t < 64 * 2 * H + 4 * H && r < 65; t++) begin
            @(negedge clk);
            if (i2s_bclk && !prev_b) begin
                r++;
                if (r >= 2) begin bits[r - 2] = i2s_sdata; lr[r - 2] = i2s_lrclk; end
            end
            prev_b = i2s_bclk;
        end
        for (int i = 0; i < 24; i++) begin
            left[23 - i]  = bits[1 + i];
            right[23 - i] = bits[33 + i];
        end
        check("t2_rises", r, 65);
        check("t2_left", left, 24'hA5A5A5);
        check("t2_right", right, 24'h5A5A5A);
        check("t2_lrclk_pattern", lr, LR_PATTERN);
        check("t2_pad_zero", bits & PAD_MASK, 0);
        check("t2_fill_after", fill_level, 0);

        // Fill while disabled; the 17th frame waits for the first pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_frame(0, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 4, ok);
            check("t3_push_ok", ok, 1);
        end
        check("t3_full", audio_full, 1);
        check("t3_level", fill_level, 16);
        d = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        push_frame(0, d, 40, ok);
        check("t3_held_while_full", ok, 0);
        enable = 1'b1; c0 = cyc;
        push_frame(0, d, 100, ok);
        check("t3_accepted", ok, 1);
        check("t3_accept_edge", cyc - c0, 2 * H + 1);
        check("t3_level_after", fill_level, 16);

        // Push coinciding with the frame-start pop at level 5.
        do_reset();
        for (int i = 0; i < 5; i++) push_frame(0, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 4, ok);
        enable = 1'b1; c0 = cyc;
        repeat (2 * H - 1) @(negedge clk);
        check("t4_level_before", fill_level, 5);
        push_frame(0, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 4, ok);
        check("t4_push_edge", cyc - c0, 2 * H);
        check("t4_level_same", fill_level, 5);

        // Reset mid right slot with three frames queued.
        do_reset();
        for (int i = 0; i < 4; i++) push_frame(0, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 4, ok);
        enable = 1'b1;
        repeat (1300) @(negedge clk);
        check("t5_in_right_slot", i2s_lrclk, 1);
        check("t5_level_before", fill_level, 3);
        reset = 1'b1;
        @(negedge clk);
        check("t5_bclk", i2s_bclk, 0);
        check("t5_lrclk", i2s_lrclk, 0);
        check("t5_sdata", i2s_sdata, 0);
        check("t5_fill", fill_level, 0);
        check("t5_full", audio_full, 0);
        reset = 1'b0; c0 = cyc;
        for (int t = 0; t < 100 && !underrun; t++) @(negedge clk);
        check("t5_first_underrun", underrun, 1);
        check("t5_underrun_edge", cyc - c0, 2 * H);

        // Random traffic with an enable drop, checked by the model every cycle.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 700)) @(negedge clk);
            if (i == 5) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 60)) @(negedge clk);
                enable = 1'b1;
            end
            push_frame(0, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, 4000, ok);
            check("t7_push_ok", ok, 1);
        end
        repeat (2500) @(negedge clk);

        // Fast divider: known frame and frame period.
        do_reset();
        push_frame(1, {24'hA5A5A5, 24'h5A5A5A}, 10, ok);
        f_en = 1'b1;
        for (int t = 0; t < 800 && f_frames < 2; t++) @(negedge clk);
        check("t6_frames", f_frames, 2);
        check("t6_data", f_last_data, 48'hA5A5A5_5A5A5A);
        check("t6_period", f_last_period, 256);

        // Fast divider: 40 sequential frames across pointer wrap, order scored by the decoder.
        do_reset();
        f_en = 1'b1;
        d = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            push_frame(1, {d[47:24] + 24'(i), d[23:0] - 24'(i)}, 2000, ok);
            check("wrap_push_ok", ok, 1);
        end
        for (int t = 0; t < 8000 && f_exp_q.size() > 0; t++) @(negedge clk);
        check("wrap_drained", f_exp_q.size(), 0);
        check("wrap_data_frames", f_data_frames, 40);
        check("wrap_fill", f_fill_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
